// File: rtl/detect_event_counter.sv
// detect_event_counter
//   Counts single-cycle detection pulses over windows of WINDOW cycles, or over
//   shorter windows ended by dropping en. Each window result is offered to a
//   consumer through a one-entry valid/ready output register. Counts saturate,
//   and a result that finds the output register occupied is dropped and flagged.
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous active-high reset
//   en            : counting enable, sampled every cycle
//   detect_in     : detection pulse
//   count_valid   : output register holds a window result
//   count_ready   : consumer accepts (transfer when count_valid && count_ready)
//   count_data    : detection count of the window
//   count_sat     : window count saturated
//   count_partial : window was closed early by en=0
//   dropped       : sticky, at least one window result was discarded
module detect_event_counter #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             detect_in,
    output logic             count_valid,
    input  logic             count_ready,
    output logic [CNT_W-1:0] count_data,
    output logic             count_sat,
    output logic             count_partial,
    output logic             dropped
);

    localparam int unsigned     TW       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0]   LAST     = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {StIdle, StCount} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;

    logic [CNT_W-1:0]  acc_next;
    logic              sat_next;
    logic              close;
    logic [CNT_W-1:0]  res_data;
    logic              res_sat;
    logic              res_partial;
    logic              load;

    // Accumulator value including this cycle's pulse; holds at max and flags.
    always_comb begin
        acc_next = acc_q;
        sat_next = sat_q;
        if (detect_in) begin
            if (acc_q == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                acc_next = acc_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        close       = 1'b0;
        res_data    = acc_q;
        res_sat     = sat_q;
        res_partial = 1'b0;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                acc_d   = '0;
                sat_d   = 1'b0;
                if (en) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                if (!en) begin
                    // Early close: this cycle's pulse is not counted.
                    close       = 1'b1;
                    res_partial = 1'b1;
                    state_d     = StIdle;
                    timer_d     = '0;
                    acc_d       = '0;
                    sat_d       = 1'b0;
                end else if (timer_q == LAST) begin
                    // Normal close: next window starts with no gap.
                    close    = 1'b1;
                    res_data = acc_next;
                    res_sat  = sat_next;
                    timer_d  = '0;
                    acc_d    = '0;
                    sat_d    = 1'b0;
                end else begin
                    timer_d = timer_q + TW'(1);
                    acc_d   = acc_next;
                    sat_d   = sat_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A close loads if the register is free or being drained this cycle.
    assign load = close && (!count_valid || count_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_valid   <= 1'b0;
            count_data    <= '0;
            count_sat     <= 1'b0;
            count_partial <= 1'b0;
            dropped       <= 1'b0;
        end else begin
            if (load) begin
                count_valid   <= 1'b1;
                count_data    <= res_data;
                count_sat     <= res_sat;
                count_partial <= res_partial;
            end else if (count_valid && count_ready) begin
                count_valid <= 1'b0;
            end
            if (close && !load) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_detect_event_counter.sv
// Testbench for detect_event_counter: two instances (CNT_W=4 and CNT_W=2,
// both WINDOW=8) share stimulus and are compared every cycle against a
// window-level reference model, plus a few fixed expectations.
module tb_detect_event_counter;

    localparam int unsigned WIN = 8;

    logic       clk;
    logic       reset;
    logic       en;
    logic       detect_in;
    logic       count_ready;

    logic       valid_a, sat_a, part_a, drop_a;
    logic [3:0] data_a;
    logic       valid_b, sat_b, part_b, drop_b;
    logic [1:0] data_b;

    int checks;
    int failures;

    detect_event_counter #(.WINDOW(WIN), .CNT_W(4)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .detect_in     (detect_in),
        .count_valid   (valid_a),
        .count_ready   (count_ready),
        .count_data    (data_a),
        .count_sat     (sat_a),
        .count_partial (part_a),
        .dropped       (drop_a)
    );

    detect_event_counter #(.WINDOW(WIN), .CNT_W(2)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .detect_in     (detect_in),
        .count_valid   (valid_b),
        .count_ready   (count_ready),
        .count_data    (data_b),
        .count_sat     (sat_b),
        .count_partial (part_b),
        .dropped       (drop_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: per instance, window membership, cycle index within the
    // window and an unbounded pulse tally; the held output is a plain record.
    int m_in_win [2];
    int m_cyc    [2];
    int m_n      [2];
    int m_valid  [2];
    int m_data   [2];
    int m_sat    [2];
    int m_part   [2];
    int m_drop   [2];
    int m_max    [2];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in_win[k] = 0; m_cyc[k] = 0; m_n[k] = 0;
            m_valid[k] = 0; m_data[k] = 0; m_sat[k] = 0; m_part[k] = 0; m_drop[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int close;
            int r_n;
            int r_part;
            close = 0; r_n = 0; r_part = 0;
            if (m_in_win[k] != 0) begin
                if (!en) begin
                    close = 1; r_n = m_n[k]; r_part = 1;
                    m_in_win[k] = 0; m_n[k] = 0; m_cyc[k] = 0;
                end else if (m_cyc[k] == WIN - 1) begin
                    close = 1; r_n = m_n[k] + int'(detect_in); r_part = 0;
                    m_n[k] = 0; m_cyc[k] = 0;
                end else begin
                    m_n[k] = m_n[k] + int'(detect_in);
                    m_cyc[k]++;
                end
            end else if (en) begin
                m_in_win[k] = 1; m_cyc[k] = 0; m_n[k] = 0;
            end
            if (close != 0) begin
                if (m_valid[k] == 0 || count_ready) begin
                    m_valid[k] = 1;
                    m_data[k]  = (r_n > m_max[k]) ? m_max[k] : r_n;
                    m_sat[k]   = (r_n > m_max[k]) ? 1 : 0;
                    m_part[k]  = r_part;
                end else begin
                    m_drop[k] = 1;
                end
            end else if (m_valid[k] != 0 && count_ready) begin
                m_valid[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("a_valid",   int'(valid_a), m_valid[0]);
        check("a_data",    int'(data_a),  m_data[0]);
        check("a_sat",     int'(sat_a),   m_sat[0]);
        check("a_partial", int'(part_a),  m_part[0]);
        check("a_dropped", int'(drop_a),  m_drop[0]);
        check("b_valid",   int'(valid_b), m_valid[1]);
        check("b_data",    int'(data_b),  m_data[1]);
        check("b_sat",     int'(sat_b),   m_sat[1]);
        check("b_partial", int'(part_b),  m_part[1]);
        check("b_dropped", int'(drop_b),  m_drop[1]);
    endtask

    // Called at a negedge: drive, let the edge happen, model it, then compare.
    task automatic cycle(input logic e, input logic d, input logic r);
        en = e; detect_in = d; count_ready = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        en = 1'b0; detect_in = 1'b0; count_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_max[0] = 15;
        m_max[1] = 3;
        model_reset();
        reset = 1'b0; en = 1'b0; detect_in = 1'b0; count_ready = 1'b0;
        @(negedge clk);

        // Reset values, then 3 idle cycles.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        check("rst_valid", int'(valid_a), 0);

        // Normal window: pulses at cycles 1, 3, 7.
        do_reset();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < WIN; i++) cycle(1'b1, (i == 1 || i == 3 || i == 7), 1'b1);
        check("t2_valid", int'(valid_a), 1);
        check("t2_data", int'(data_a), 3);
        check("t2_partial", int'(part_a), 0);
        for (int i = 0; i < WIN - 1; i++) cycle(1'b1, 1'b1, 1'b1);
        check("t2_gap_valid", int'(valid_a), 0);
        cycle(1'b1, 1'b0, 1'b1);
        check("t2_next_valid", int'(valid_a), 1);
        check("t2_next_data", int'(data_a), 7);

        // Saturation: 8 pulses into a 2-bit count.
        do_reset();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < WIN; i++) cycle(1'b1, 1'b1, 1'b1);
        check("t3_b_data", int'(data_b), 3);
        check("t3_b_sat", int'(sat_b), 1);
        check("t3_a_data", int'(data_a), 8);

        // Backpressure and drop, then transfer + load in the same cycle.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) cycle(1'b1, (i < 2), 1'b0);
        for (int i = 0; i < WIN; i++) cycle(1'b1, 1'b1, 1'b0);
        check("t4_held_data", int'(data_a), 2);
        check("t4_dropped", int'(drop_a), 1);
        for (int i = 0; i < WIN; i++) cycle(1'b1, (i < 5), (i == WIN - 1));
        check("t4_valid", int'(valid_a), 1);
        check("t4_new_data", int'(data_a), 5);
        cycle(1'b1, 1'b0, 1'b1);

        // Early close at cycle 5 with a pulse that must not count.
        do_reset();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, (i == 1 || i == 3), 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("t5_data", int'(data_a), 2);
        check("t5_partial", int'(part_a), 1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1);
        check("t5_idle_valid", int'(valid_a), 0);

        // Reset mid-window with 3 pulses accumulated.
        do_reset();
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, (i < 3), 1'b1);
        do_reset();
        cycle(1'b0, 1'b0, 1'b1);
        check("t6_no_result", int'(valid_a), 0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < WIN; i++) cycle(1'b1, (i == 2 || i == 6), 1'b1);
        check("t6_data", int'(data_a), 2);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 19) != 0),
                      ($urandom_range(0, 99) < 60),
                      ($urandom_range(0, 99) < 65));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
